// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: alternating-priority arbiter in front of a start/8-data/stop serializer.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx_scheduler #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state, state_nx;
  logic       rst_meta, rst_sync;
  logic       arb_en, last_grant, sel1, accept, stop_last;
  logic [2:0] bit_cnt;
  logic [1:0] stop_cnt;
  logic [7:0] shreg, acc_data;
`ifdef UART_TX_PARITY_EN
  logic       par_bit;
`endif

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  assign sel1      = req1_valid && (!req0_valid || !last_grant);
  assign accept    = req0_ready || req1_ready;
  assign acc_data  = sel1 ? req1_data : req0_data;
  assign stop_last = (stop_cnt == STOP_LAST);

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (accept)    state_nx = WAIT_START;
      WAIT_START: if (baud_tick) state_nx = START;
      START:      if (baud_tick) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:       if (baud_tick && bit_cnt == 3'd7) state_nx = PARITY;
      PARITY:     if (baud_tick) state_nx = STOP;
`else
      DATA:       if (baud_tick && bit_cnt == 3'd7) state_nx = STOP;
`endif
      STOP:       if (baud_tick && stop_last) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // arb_en keeps ready low until the first edge after the synchronized release.
  always_comb begin
    req0_ready = arb_en && (state == IDLE) && req0_valid && !sel1;
    req1_ready = arb_en && (state == IDLE) && sel1;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      arb_en     <= 1'b0;
      tx         <= 1'b1;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 2'd0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      arb_en <= 1'b1;
      if (accept) begin
        grant_id   <= sel1;
        last_grant <= sel1;
      end
      if (baud_tick) begin
        case (state)
          WAIT_START: tx <= 1'b0;
          START: begin
            tx      <= shreg[0];
            bit_cnt <= 3'd0;
          end
          DATA: begin
            if (bit_cnt != 3'd7) begin
              tx      <= shreg[0];
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx <= par_bit;
`else
              tx <= 1'b1;
`endif
              bit_cnt <= 3'd0;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: tx <= 1'b1;
`endif
          STOP: begin
            tx       <= 1'b1;
            stop_cnt <= stop_last ? 2'd0 : stop_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Data bits leave from shreg[0]; the register shifts right on every START/DATA tick.
  always_ff @(posedge clk) begin
    if (accept)
      shreg <= acc_data;
    else if (baud_tick && (state == START || state == DATA))
      shreg <= {1'b0, shreg[7:1]};
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (accept) par_bit <= ^acc_data;
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed bytes, serial-line monitor decoding frames.
module tb_uart_tx_scheduler;
  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB1 = 11;
  localparam int NB2 = 13;
  localparam logic [15:0] F_A5 = 16'({1'b1, 1'b0, 8'hA5, 1'b0});
  localparam logic [15:0] F_07 = 16'({1'b1, 1'b1, 8'h07, 1'b0});
  localparam logic [15:0] F_03 = 16'({1'b1, 1'b0, 8'h03, 1'b0});
  localparam logic [15:0] F_3C = 16'({3'b111, 1'b0, 8'h3C, 1'b0});
`else
  localparam int NB1 = 10;
  localparam int NB2 = 12;
  localparam logic [15:0] F_A5 = 16'({1'b1, 8'hA5, 1'b0});
  localparam logic [15:0] F_07 = 16'({1'b1, 8'h07, 1'b0});
  localparam logic [15:0] F_03 = 16'({1'b1, 8'h03, 1'b0});
  localparam logic [15:0] F_3C = 16'({3'b111, 8'h3C, 1'b0});
`endif

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic req0_ready, req1_ready, tx, busy, grant_id;
  logic b_valid = 1'b0;
  logic [7:0] b_data = 8'h3C;
  logic b_r0_ready, b_ready, b_tx, b_busy, b_grant;

  exp_t sbq[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  uart_tx_scheduler #(.STOP_BITS(1)) dut_s1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_scheduler #(.STOP_BITS(2)) dut_s2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req0_valid(1'b0), .req0_data(8'h00), .req0_ready(b_r0_ready),
    .req1_valid(b_valid), .req1_data(b_data), .req1_ready(b_ready),
    .tx(b_tx), .busy(b_busy), .grant_id(b_grant)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      baud_tick = (ph == BAUD - 1);
      ph = (ph + 1) % BAUD;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? tx : b_tx;
  endfunction

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!baud_tick && n < 4 * BAUD);
  endtask

  // Seek the next start bit, then record nbits tick samples (bit 0 = start bit).
  task automatic capture(input int which, input int nbits, output logic [15:0] v, output int t0);
    int n;
    n = 0;
    do begin
      wait_tick();
      n++;
    end while (line(which) !== 1'b0 && n < 40);
    t0 = cyc;
    v = '0;
    v[0] = line(which);
    for (int i = 1; i < nbits; i++) begin
      wait_tick();
      v[i] = line(which);
    end
  endtask

  task automatic drive(input int id, input logic [7:0] d);
    int n;
    logic rdy;
    @(negedge clk);
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; end
    else         begin req1_valid = 1'b1; req1_data = d; end
    n = 0;
    forever begin
      #1;
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) break;
      n++;
      if (n > 300) begin
        check("drive_ready_timeout", rdy, 1'b1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", {busy, sbq.size() != 0}, 2'b00);
  endtask

  // Monitor: decodes the dut_s1 serial line and compares each frame with the scoreboard head.
  initial begin
    int mst;
    int nb;
    logic [7:0] sh;
    logic gid;
    logic pbit;
    exp_t e;
    mst = 0; nb = 0; sh = '0; gid = 1'b0; pbit = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mst = 0;
        continue;
      end
      if (!baud_tick) continue;
      case (mst)
        0: if (tx === 1'b0) begin
          check("mon_busy_in_frame", busy, 1'b1);
          gid = grant_id;
          nb = 0;
          sh = '0;
          mst = 1;
        end
        1: begin
          sh = {tx, sh[7:1]};
          nb++;
`ifdef UART_TX_PARITY_EN
          if (nb == 8) mst = 2;
`else
          if (nb == 8) mst = 3;
`endif
        end
        2: begin
          pbit = tx;
          mst = 3;
        end
        default: begin
          check("mon_stop_bit", tx, 1'b1);
          check("mon_frame_expected", sbq.size() > 0, 1'b1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("mon_data", sh, e.data);
            check("mon_grant_id", gid, e.id);
`ifdef UART_TX_PARITY_EN
            check("mon_parity", pbit, ^e.data);
`endif
          end
          mst = 0;
        end
      endcase
    end
  end

  initial begin
    logic [15:0] v;
    int t0, t1, t2, n, lo_cnt;
    logic hi_ok;

    // Reset state, with both requesters asking during reset
    #2 rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_grant_id", grant_id, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Tie after reset: req0 wins, then req1
    sbq.push_back({1'b0, 8'h11});
    sbq.push_back({1'b1, 8'h22});
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    #1;
    check("tie_req0_ready", req0_ready, 1'b1);
    check("tie_req1_ready", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    check("tie_req0_ready_pulse", req0_ready, 1'b0);
    req0_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!req1_ready && n < 300);
    check("tie_req1_ready_later", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    check("tie_req1_ready_pulse", req1_ready, 1'b0);
    req1_valid = 1'b0;
    wait_idle();

    // 0xA5 from req0: bit sequence and busy duration
    sbq.push_back({1'b0, 8'hA5});
    drive(0, 8'hA5);
    capture(0, NB1, v, t0);
    check("a5_frame_bits", v, F_A5);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    t1 = cyc;
    check("a5_busy_periods", t1 - t0, NB1 * BAUD);
    check("a5_grant_id", grant_id, 1'b0);
    wait_idle();

    // 0x07 and 0x03 from req1: parity 1 and 0 when parity is built in
    sbq.push_back({1'b1, 8'h07});
    drive(1, 8'h07);
    capture(0, NB1, v, t0);
    check("f07_frame_bits", v, F_07);
    wait_idle();
    sbq.push_back({1'b1, 8'h03});
    drive(1, 8'h03);
    capture(0, NB1, v, t0);
    check("f03_frame_bits", v, F_03);
    wait_idle();

    // Acceptance coinciding with baud_tick: start bit waits for the next tick
    sbq.push_back({1'b0, 8'h81});
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!baud_tick && n < 4 * BAUD);
    req0_valid = 1'b1; req0_data = 8'h81;
    #1;
    check("tick_acc_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    check("tick_acc_tx_high", tx, 1'b1);
    check("tick_acc_busy", busy, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    hi_ok = 1'b1;
    for (int k = 1; k < BAUD; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) hi_ok = 1'b0;
    end
    check("tick_wait_start_high", hi_ok, 1'b1);
    lo_cnt = 0;
    for (int k = 0; k < BAUD; k++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) lo_cnt++;
    end
    check("tick_start_bit_len", lo_cnt, BAUD);
    @(posedge clk); #1;
    check("tick_first_data_bit", tx, 1'b1);
    wait_idle();

    // Reset during data bit 4 of 0xFF from req1, then 0x55 from req1
    drive(1, 8'hFF);
    n = 0;
    do begin
      wait_tick();
      n++;
    end while (tx !== 1'b0 && n < 40);
    repeat (5) wait_tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_grant_id", grant_id, 1'b0);
    check("midrst_req1_ready", req1_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_release_idle", {tx, busy}, 2'b10);
    sbq.push_back({1'b1, 8'h55});
    drive(1, 8'h55);
    wait_idle();
    check("midrst_grant_after", grant_id, 1'b1);

    // Two stop bits, req1 held valid: back-to-back frames 0x3C
    @(negedge clk);
    b_valid = 1'b1;
    capture(1, NB2, v, t0);
    check("s2_frame0", v, F_3C);
    capture(1, NB2, v, t1);
    check("s2_frame1", v, F_3C);
    check("s2_spacing01", t1 - t0, NB2 * BAUD);
    capture(1, NB2, v, t2);
    check("s2_frame2", v, F_3C);
    check("s2_spacing12", t2 - t1, NB2 * BAUD);
    check("s2_grant_id", b_grant, 1'b1);
    @(negedge clk);
    b_valid = 1'b0;
    n = 0;
    while (b_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("s2_drain", b_busy, 1'b0);

    check("sb_empty_at_end", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter: STOP_BITS, 1, number of stop bits per frame (legal values 1 or 2).
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: baud_tick  input  1  one-cycle pulse per bit period, driven by the baud-rate generator's TX enable.
REQ-005 SHALL have ports: req0_valid  input  1 / req0_data  input  8 / req0_ready  output  1  requester 0 byte handshake.
REQ-006 SHALL have ports: req1_valid  input  1 / req1_data  input  8 / req1_ready  output  1  requester 1 byte handshake.
REQ-007 SHALL have port: tx  output  1  serial line, idle high, registered.
REQ-008 SHALL have port: busy  output  1  high while a frame is queued or being sent.
REQ-009 SHALL have port: grant_id  output  1  index of the requester owning the current or last frame.

Function
REQ-010 SHALL implement states IDLE, WAIT_START, START, DATA, [PARITY], STOP.
REQ-011 reqN_ready SHALL be combinational: high only in IDLE, and only for the requester the arbiter selects this cycle.
REQ-012 Arbiter: one valid -> that one selected; both valid -> requester not granted last; last_grant resets to 1, so req0 wins the first tie.
REQ-013 Transfer occurs when valid & ready; data latched into an 8-bit shift register, grant_id/last_grant updated, state -> WAIT_START.
REQ-014 Requester SHALL hold valid and data stable until ready; dropping valid before ready is legal and produces no transfer.
REQ-015 A baud_tick in the acceptance cycle SHALL be ignored; in WAIT_START the next baud_tick drives tx=0 and moves to START, guaranteeing a full start bit.
REQ-016 START: on baud_tick, tx=data[0], bit counter=0, -> DATA.
REQ-017 DATA: on baud_tick, if bit counter <7, tx=next bit LSB-first, counter+1; at 7 -> PARITY (macro defined) or STOP with tx=1.
REQ-018 STOP: tx held 1; stop counter counts baud_ticks; after STOP_BITS ticks in STOP -> IDLE (tx stays 1).
REQ-019 tx, state, and counters SHALL change only on cycles with baud_tick, except the IDLE -> WAIT_START acceptance.
REQ-020 baud_tick in IDLE SHALL have no effect; a new frame can be accepted in the cycle after entry to IDLE.
REQ-021 busy SHALL be 0 in IDLE, 1 in every other state.
REQ-022 No back-to-back acceptance without returning to IDLE; at most one byte held internally.

Reset
REQ-023 On rst low (any cycle, including mid-frame): tx=1, busy=0, req0_ready=req1_ready=0, grant_id=0, last_grant=1, counters=0, state=IDLE; the in-flight frame is discarded.
REQ-024 Reset release SHALL be synchronized to clk so the first post-reset edge sees a stable IDLE.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, PARITY state inserted after data bit 7; on baud_tick tx=even parity (XOR of 8 data bits), next baud_tick -> STOP with tx=1.
REQ-026 Without UART_TX_PARITY_EN: no PARITY state, no parity logic; frame = 1 start + 8 data + STOP_BITS stop.

Verification
REQ-027 req0 sends 0xA5, STOP_BITS=1, parity off -> tx per bit period: 0,1,0,1,0,0,1,0,1,1; busy high 10 baud periods after WAIT_START; grant_id=0.
REQ-028 req0_valid and req1_valid rise same cycle (0x11, 0x22), both held -> 0x11 sent first, then 0x22; grant_id 0 then 1; ready pulses one cycle each.
REQ-029 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after data; send 0x03 -> parity bit 0; frame 11 bits.
REQ-030 rst low during data bit 4 of 0xFF -> tx=1 and busy=0 immediately; after release, next req1 byte 0x55 sent intact, grant_id=1.
REQ-031 baud_tick asserted in acceptance cycle -> tx stays 1 until the following baud_tick; start bit lasts exactly one full period.
REQ-032 STOP_BITS=2, req1 continuously valid with 0x3C -> frames separated by exactly 2 high bit periods plus WAIT_START latency; never requires more than 1 byte buffered.
